// File: rtl/id_arb2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : id_arb2_pkg
//  Description : Shared constants, state encodings and the character
//                classifier for the two-port identifier front end.
//  Revision    : 1.0 - initial release
// ============================================================================
package id_arb2_pkg;

    // Character class bounds (ASCII)
    localparam logic [7:0] C_UPPER_LO = 8'd65;   // 'A'
    localparam logic [7:0] C_UPPER_HI = 8'd90;   // 'Z'
    localparam logic [7:0] C_LOWER_LO = 8'd97;   // 'a'
    localparam logic [7:0] C_LOWER_HI = 8'd122;  // 'z'
    localparam logic [7:0] C_DIGIT_LO = 8'd48;   // '0'
    localparam logic [7:0] C_DIGIT_HI = 8'd57;   // '9'

    typedef enum logic [1:0] {
        CLS_OTHER  = 2'd0,
        CLS_LETTER = 2'd1,
        CLS_DIGIT  = 2'd2
    } char_class_t;

    typedef enum logic [1:0] {
        REC_IDLE = 2'd0,
        REC_LET  = 2'd1,
        REC_DIG  = 2'd2
    } rec_state_t;

    typedef enum logic [1:0] {
        CTRL_ARB    = 2'd0,
        CTRL_BUSY   = 2'd1,
        CTRL_REPORT = 2'd2
    } ctrl_state_t;

    // Classify one ASCII character
    function automatic char_class_t char_class(input logic [7:0] c);
        char_class_t cls;
        cls = CLS_OTHER;
        if ((c >= C_UPPER_LO && c <= C_UPPER_HI) ||
            (c >= C_LOWER_LO && c <= C_LOWER_HI)) begin
            cls = CLS_LETTER;
        end else if (c >= C_DIGIT_LO && c <= C_DIGIT_HI) begin
            cls = CLS_DIGIT;
        end
        return cls;
    endfunction

endpackage
`default_nettype wire

// File: rtl/id_arb2_if.sv
`default_nettype none
// ============================================================================
//  Module      : id_arb2_if
//  Description : Requester A/B character streams and the result strobe
//                of the two-port identifier front end.
//  Revision    : 1.0 - initial release
// ============================================================================
interface id_arb2_if #(
    parameter int LEN_W = 8
);
    logic [7:0]       a_char;
    logic             a_valid;
    logic             a_last;
    logic             a_ready;
    logic [7:0]       b_char;
    logic             b_valid;
    logic             b_last;
    logic             b_ready;
    logic             res_valid;
    logic             res_id;
    logic             res_match;
    logic [LEN_W-1:0] res_len;
    logic [LEN_W-1:0] res_tok;

    // Arbiter side
    modport slave (
        input  a_char, a_valid, a_last,
        input  b_char, b_valid, b_last,
        output a_ready, b_ready,
        output res_valid, res_id, res_match, res_len, res_tok
    );

    // Requester / consumer side
    modport master (
        output a_char, a_valid, a_last,
        output b_char, b_valid, b_last,
        input  a_ready, b_ready,
        input  res_valid, res_id, res_match, res_len, res_tok
    );
endinterface
`default_nettype wire

// File: rtl/id_arb2_rec.sv
`default_nettype none
// ============================================================================
//  Module      : id_rec
//  Description : Identifier recognizer IDLE/LET/DIG. Steps on accepted
//                characters, flags LET->DIG transitions with tok_inc.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_rec
    import id_arb2_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic       step,
    input  wire logic       clear,
    input  wire logic [7:0] char_in,
    output rec_state_t      state,
    output logic            tok_inc
);

    rec_state_t  state_q;
    rec_state_t  state_d;
    char_class_t cls;

    // Next recognizer state; clear wins over step
    always_comb begin
        cls     = char_class(char_in);
        state_d = state_q;
        tok_inc = 1'b0;
        if (clear) begin
            state_d = REC_IDLE;
        end else if (step) begin
            case (cls)
                CLS_LETTER: state_d = REC_LET;
                CLS_DIGIT:  state_d = (state_q == REC_IDLE) ? REC_IDLE : REC_DIG;
                default:    state_d = REC_IDLE;
            endcase
            tok_inc = (state_q == REC_LET) && (state_d == REC_DIG);
        end
    end

    // Recognizer state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= REC_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule
`default_nettype wire

// File: rtl/id_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : id_arb2
//  Description : Round-robin two-port frame arbiter in front of the
//                identifier recognizer; reports match/len/tok per frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_arb2
    import id_arb2_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  wire logic  clk,
    input  wire logic  reset,
    id_arb2_if.slave   bus
);

    ctrl_state_t      state_q,     state_d;
    logic             owner_q,     owner_d;      // 0 = A, 1 = B
    logic             prio_q,      prio_d;       // requester preferred on a tie
    logic [LEN_W-1:0] len_q,       len_d;
    logic [LEN_W-1:0] tok_q,       tok_d;
    logic             res_id_q,    res_id_d;     // held copies shown between strobes
    logic             res_match_q, res_match_d;
    logic [LEN_W-1:0] res_len_q,   res_len_d;
    logic [LEN_W-1:0] res_tok_q,   res_tok_d;

    logic             a_rdy;
    logic             b_rdy;
    logic             xfer;
    logic             sel_last;
    logic [7:0]       sel_char;
    logic             rec_step;
    logic             rec_clear;
    rec_state_t       rec_state;
    logic             tok_inc;

    // Counter increment that sticks at all ones
    function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
        return (&v) ? v : v + {{(LEN_W-1){1'b0}}, 1'b1};
    endfunction

    // Ready comes only from registered state, never from valid
    always_comb begin
        a_rdy    = (state_q == CTRL_BUSY) && !owner_q;
        b_rdy    = (state_q == CTRL_BUSY) &&  owner_q;
        sel_char = owner_q ? bus.b_char : bus.a_char;
        sel_last = owner_q ? bus.b_last : bus.a_last;
        xfer     = owner_q ? (bus.b_valid && b_rdy) : (bus.a_valid && a_rdy);
    end

    // Controller next-state, counters and result capture
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        prio_d      = prio_q;
        len_d       = len_q;
        tok_d       = tok_q;
        res_id_d    = res_id_q;
        res_match_d = res_match_q;
        res_len_d   = res_len_q;
        res_tok_d   = res_tok_q;
        rec_step    = 1'b0;
        rec_clear   = 1'b0;
        case (state_q)
            CTRL_ARB: begin
                if (bus.a_valid || bus.b_valid) begin
                    owner_d = (bus.a_valid && bus.b_valid) ? prio_q : bus.b_valid;
                    len_d   = '0;
                    tok_d   = '0;
                    state_d = CTRL_BUSY;
                end
            end
            CTRL_BUSY: begin
                if (xfer) begin
                    rec_step = 1'b1;
                    len_d    = sat_inc(len_q);
                    if (tok_inc) begin
                        tok_d = sat_inc(tok_q);
                    end
                    if (sel_last) begin
                        state_d = CTRL_REPORT;
                    end
                end
            end
            CTRL_REPORT: begin
                rec_clear   = 1'b1;
                prio_d      = ~owner_q;
                res_id_d    = owner_q;
                res_match_d = (rec_state == REC_DIG);
                res_len_d   = len_q;
                res_tok_d   = tok_q;
                state_d     = CTRL_ARB;
            end
            default: state_d = CTRL_ARB;
        endcase
    end

    // Controller registers; reset discards any partial frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= CTRL_ARB;
            owner_q     <= 1'b0;
            prio_q      <= 1'b0;
            len_q       <= '0;
            tok_q       <= '0;
            res_id_q    <= 1'b0;
            res_match_q <= 1'b0;
            res_len_q   <= '0;
            res_tok_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            prio_q      <= prio_d;
            len_q       <= len_d;
            tok_q       <= tok_d;
            res_id_q    <= res_id_d;
            res_match_q <= res_match_d;
            res_len_q   <= res_len_d;
            res_tok_q   <= res_tok_d;
        end
    end

    id_rec u_rec (
        .clk     (clk),
        .reset   (reset),
        .step    (rec_step),
        .clear   (rec_clear),
        .char_in (sel_char),
        .state   (rec_state),
        .tok_inc (tok_inc)
    );

    // Live values during REPORT, held copies otherwise
    assign bus.a_ready   = a_rdy;
    assign bus.b_ready   = b_rdy;
    assign bus.res_valid = (state_q == CTRL_REPORT);
    assign bus.res_id    = (state_q == CTRL_REPORT) ? owner_q                  : res_id_q;
    assign bus.res_match = (state_q == CTRL_REPORT) ? (rec_state == REC_DIG)   : res_match_q;
    assign bus.res_len   = (state_q == CTRL_REPORT) ? len_q                    : res_len_q;
    assign bus.res_tok   = (state_q == CTRL_REPORT) ? tok_q                    : res_tok_q;

endmodule
`default_nettype wire

// File: doc/id_arb2.md
# id_arb2

Two-port arbitrated front end for the identifier recognizer. Requesters A and B each stream framed character sequences; the block grants one frame at a time in round-robin order and steps a resettable identifier recognizer with each accepted character. At frame end it reports whether the frame ended in identifier-match state, plus the frame length and token count. It sits between the character sources and downstream logic that consumes identifier results.

## Interface
- LEN_W, 8: width of the frame-length and token counters; both saturate.
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- a_char  in  8  requester A character (ASCII)
- a_valid  in  1  A presents a character
- a_last  in  1  A character is the last of its frame
- a_ready  out  1  A character accepted this cycle when a_valid & a_ready
- b_char, b_valid, b_last, b_ready  same widths and meanings for requester B
- res_valid  out  1  one-cycle result strobe
- res_id  out  1  frame owner: 0 = A, 1 = B
- res_match  out  1  recognizer in DIG after the frame's last character
- res_len  out  LEN_W  characters accepted in the frame (saturating)
- res_tok  out  LEN_W  LET→DIG transitions in the frame (saturating)

## Operation
- Character classes: LETTER = 'A'..'Z' (65–90) or 'a'..'z' (97–122); DIGIT = '0'..'9' (48–57); everything else is OTHER.
- Recognizer states: IDLE, LET, DIG. Next state:
  - LETTER → LET from any state.
  - DIGIT → DIG from LET or DIG; from IDLE it stays IDLE.
  - OTHER → IDLE.
- Recognizer steps only on an accepted character. It is cleared to IDLE by reset and on leaving REPORT.
- Controller states: ARB, BUSY, REPORT.
  - ARB: if either valid is high, latch the owner and go to BUSY. If both are high, pick the one indicated by the priority pointer. Clear len and tok in the same edge.
  - BUSY: ready = 1 for the owner only; the other requester's ready = 0 and its valid is ignored. Each transfer steps the recognizer, increments len, and increments tok if the transition is LET→DIG. A transfer with last=1 goes to REPORT.
  - REPORT: res_valid = 1 with res_id = owner, res_match = (recognizer state == DIG), res_len and res_tok. Next edge: clear the recognizer, set the priority pointer to the non-owner, return to ARB.
- Owner deasserting valid mid-frame stalls with no timeout. The grant is held until last.
- Counters saturate at 2^LEN_W−1. Width rule: the increment is suppressed when the counter is all ones.
- res_* fields are valid only while res_valid = 1. Between strobes they hold their last value.

## Timing
- Reset values:
  - State ARB, recognizer IDLE, priority pointer = A.
  - a_ready = b_ready = 0.
  - res_valid = 0, res_id = 0, res_match = 0, res_len = 0, res_tok = 0.
- a_ready and b_ready are decoded from registered state. They have no combinational path from valid.
- Grant latency: valid rises in cycle N (state ARB); ready is high from cycle N+1.
- Result latency: last character accepted at edge E; res_valid is high for exactly the cycle following E.
- Back-to-back frames: the next grant decision occurs in the ARB cycle after REPORT, giving a minimum 2-cycle gap (REPORT + ARB) between frames.
- Reset asserted mid-frame immediately clears all state. The partial frame is discarded and no result is issued.

## Structure
- Shared package constants: character class bounds (65, 90, 97, 122, 48, 57), recognizer state encodings (IDLE/LET/DIG), controller state encodings (ARB/BUSY/REPORT).
- Sub-module id_rec: recognizer with clk, reset, step, clear, char in; state and a tok_inc pulse out. The arbiter and counters live in the top.

## Test plan
- Reset, then A sends "ab12" (last on '2') → ready from the cycle after valid; one res_valid with id=0, match=1, len=4, tok=1.
- A and B both valid from reset; A sends "x", B sends "9" → A granted first: result id=0, match=0, len=1, tok=0. Then B granted: result id=1, match=0, len=1, tok=0.
- A sends "a1b2c" → match=0, len=5, tok=2. A sends "1a" → match=0, tok=0. A sends "a_1" → match=0, tok=0.
- LEN_W=8, A sends 300 chars "a1a1…" → len=255, tok=150 saturated to 150 (≤255), match=1.
- During A's frame, pulse B valid and drop A valid for 5 cycles → b_ready stays 0; no result until A's last; B granted next.
- Assert reset mid-frame after "ab" → outputs return to reset values, no res_valid. Post-reset frame "z9" → match=1, len=2.
